imem_line_server: RTL and testbench
===================================

Name: imem_line_server

Overview:
- Instruction-side memory responder for the fetch stage. It serves `pc_imem` requests and returns `instr_imem` in the same cycle.
- It is backed by a slow external memory port with a valid/ready request and a multi-beat response.
- It holds one line buffer of LINE_WORDS words. On a miss it raises `stall_imem`, which the hazard unit turns into `stall_if`. While the miss is outstanding it returns NOP.

Parameters:
- LINE_WORDS, 4, 32-bit words per line; power of two, at least 2.
- NOP_INSTR, 32'h00000013, instruction returned whenever there is no hit (`addi x0,x0,0`).
- Widths use `XLEN from constants.vh.
- Derived: OFF = $clog2(LINE_WORDS)+2 = 4. Tag = pc[XLEN-1:OFF]; word index = pc[OFF-1:2].

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc_imem  input  XLEN  fetch PC, byte address; pc[1:0] ignored.
- instr_imem  output  XLEN  instruction for pc_imem; combinational from the line buffer.
- stall_imem  output  1  high when pc_imem misses; combinational.
- invalidate  input  1  one-cycle pulse (fence.i); drops the buffered line.
- mem_req_valid  output  1  line request valid.
- mem_req_ready  input  1  memory accepts the request.
- mem_req_addr  output  XLEN  line base byte address, low OFF bits zero.
- mem_rsp_valid  input  1  response beat valid; no backpressure.
- mem_rsp_data  input  XLEN  response beat; beats arrive in ascending word order.

Behaviour:
- Hit = line_valid && (tag_reg == pc_imem[XLEN-1:OFF]).
  - On hit: `instr_imem` = line[word index] and `stall_imem` = 0.
  - Otherwise: `instr_imem` = NOP_INSTR and `stall_imem` = 1.
- Reset is asynchronous and active-low. On reset:
  - State = IDLE; line_valid = 0; tag_reg = 0; beat_cnt = 0; drop = 0.
  - `mem_req_valid` = 0 and `mem_req_addr` = 0.
  - Consequently `stall_imem` = 1 and `instr_imem` = NOP immediately.
  - Line data need not be reset.
- The FSM has three states: IDLE, REQ, FILL.
- IDLE:
  - On a miss with invalidate low: latch req_tag = pc tag, clear line_valid, clear drop, and go to REQ.
  - With invalidate high: clear line_valid and stay in IDLE; the miss is serviced next cycle.
- REQ:
  - `mem_req_valid` = 1 and `mem_req_addr` = {req_tag, OFF'b0}. Both are registered and held stable until the handshake.
  - When `mem_req_valid` && `mem_req_ready`: deassert `mem_req_valid`, set beat_cnt = 0, and go to FILL.
- FILL:
  - Each `mem_rsp_valid` writes line[beat_cnt] = `mem_rsp_data` and increments beat_cnt.
  - On beat LINE_WORDS-1: tag_reg = req_tag, line_valid = !drop (and not invalidate that same cycle), then go to IDLE.
- `mem_rsp_valid` outside FILL is ignored; no write and no error.
- The line is never partially valid. No hit is possible during REQ/FILL, so `stall_imem` stays 1 throughout a fill.
- PC change mid-fill (fetch flush overrides stall):
  - The fill in progress still completes for req_tag.
  - Back in IDLE, the new PC is re-evaluated; if it misses, a new fill starts the following cycle.
- `invalidate` during REQ/FILL sets drop. The fill completes, but line_valid stays 0.
- Exactly one request is outstanding at a time. There is no request abort.
- Minimum miss latency, with ready held high and back-to-back beats:
  - Cycle 0: miss detected.
  - Cycle 1: request handshake.
  - Cycles 2..5: beats.
  - Cycle 6: hit, `stall_imem` = 0.
- Reset asserted mid-fill returns everything to reset state immediately. Later beats are ignored because the state is IDLE.

Test Plan:
- Reset release, pc_imem=0x0:
  - `stall_imem`=1 and `instr_imem`=0x00000013.
  - One request with `mem_req_addr`=0x0.
  - Beats 0xA0,0xA1,0xA2,0xA3 → at cycle 6 `stall_imem`=0 and `instr_imem`=0xA0.
  - pc_imem=0xC → 0xA3 with no new request.
- Line 0x0 valid, pc_imem=0x10:
  - Miss, `mem_req_addr`=0x10.
  - `mem_req_ready` held low 3 cycles: `mem_req_valid` and addr stay stable, `stall_imem`=1.
  - After fill, pc_imem=0x0 misses again (single line).
- pc_imem moves 0x20→0x40 during FILL of 0x20:
  - Fill of 0x20 completes.
  - The next cycle issues a request for 0x40; no hit on 0x40 until its own fill completes.
- invalidate pulse during FILL of line 0x30:
  - After the last beat, line_valid=0 and `stall_imem`=1.
  - A new request for 0x30 is issued.
- Stray `mem_rsp_valid` in IDLE with a valid line: line contents unchanged and hits continue.
- rst_n low mid-FILL (after 2 beats): outputs immediately at reset values; remaining beats ignored; a fresh request is issued after release.

Source files
------------

// File: rtl/imem_line_server.sv
// imem_line_server: single-line instruction buffer; a miss stalls fetch and refills
// the line from a slow request/multi-beat-response memory port.
`ifndef XLEN
`define XLEN 32
`endif
module imem_line_server #(
  parameter int LINE_WORDS = 4,
  parameter logic [`XLEN-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [`XLEN-1:0] pc_imem,
  output logic [`XLEN-1:0] instr_imem,
  output logic             stall_imem,
  input  logic             invalidate,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [`XLEN-1:0] mem_req_addr,
  input  logic             mem_rsp_valid,
  input  logic [`XLEN-1:0] mem_rsp_data
);
  localparam int XLEN = `XLEN;
  localparam int IW = $clog2(LINE_WORDS);
  localparam int OFF = IW + 2;
  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;
  state_t state;
  logic line_valid;
  logic drop;
  logic hit;
  logic unused_pc;
  logic [XLEN-OFF-1:0] tag_reg;
  logic [XLEN-OFF-1:0] req_tag;
  logic [XLEN-OFF-1:0] pc_tag;
  logic [IW-1:0] beat_cnt;
  logic [XLEN-1:0] line [LINE_WORDS];
  assign pc_tag = pc_imem[XLEN-1:OFF];
  assign hit = line_valid && tag_reg == pc_tag;
  assign stall_imem = !hit;
  assign instr_imem = hit ? line[pc_imem[OFF-1:2]] : NOP_INSTR;
  assign unused_pc = ^pc_imem[1:0];
  // line data carries no reset; it is only ever read under line_valid
  always_ff @(posedge clk)
    if (state == FILL && mem_rsp_valid) line[beat_cnt] <= mem_rsp_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      line_valid <= 1'b0;
      tag_reg <= '0;
      req_tag <= '0;
      beat_cnt <= '0;
      drop <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr <= '0;
    end else begin
      case (state)
        IDLE:
          if (invalidate) line_valid <= 1'b0;
          else if (!hit) begin
            req_tag <= pc_tag;
            line_valid <= 1'b0;
            drop <= 1'b0;
            mem_req_valid <= 1'b1;
            mem_req_addr <= {pc_tag, {OFF{1'b0}}};
            state <= REQ;
          end
        REQ: begin
          if (invalidate) drop <= 1'b1;
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            beat_cnt <= '0;
            state <= FILL;
          end
        end
        FILL: begin
          if (invalidate) drop <= 1'b1;
          if (mem_rsp_valid) begin
            beat_cnt <= beat_cnt + 1'b1;
            // a fence.i seen at any point during the fill leaves the line invalid
            if (beat_cnt == IW'(LINE_WORDS - 1)) begin
              tag_reg <= req_tag;
              line_valid <= !drop && !invalidate;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_imem_line_server.sv
// tb_imem_line_server: randomized scoreboard bench; an abstract line/memory model predicts
// every cycle's fetch outputs and request, a monitor compares them on the falling edge.
module tb_imem_line_server;
  localparam int W = 4;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] pc_imem = '0;
  logic [31:0] instr_imem;
  logic stall_imem;
  logic invalidate = 1'b0;
  logic mem_req_valid;
  logic mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  imem_line_server #(.LINE_WORDS(W)) dut (
    .clk(clk), .rst_n(rst_n), .pc_imem(pc_imem), .instr_imem(instr_imem),
    .stall_imem(stall_imem), .invalidate(invalidate), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic stall;
    logic [31:0] instr;
    logic rv;
    logic ca;
    logic [31:0] ra;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int passed = 0;
  logic [31:0] mem_words [256];
  bit lv, busy, req_out, drop;
  logic [31:0] line_addr = '0;
  logic [31:0] req_addr = '0;
  int beats = 0;
  int p_ready = 100;
  int p_beat = 100;
  int p_stray = 0;
  task automatic chk(input string n, input logic [31:0] e, input logic [31:0] a);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
  endtask
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("stall", {31'b0, e.stall}, {31'b0, stall_imem});
      chk("instr", e.instr, instr_imem);
      chk("req_valid", {31'b0, e.rv}, {31'b0, mem_req_valid});
      if (e.ca) chk("req_addr", e.ra, mem_req_addr);
    end
  end
  task automatic step();
    bit hit, filling;
    exp_t e;
    if (!rst_n) begin
      lv = 0; busy = 0; req_out = 0; drop = 0; beats = 0;
    end
    filling = busy && !req_out;
    mem_req_ready = $urandom_range(0, 99) < p_ready;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = $urandom;
    if (filling) begin
      if ($urandom_range(0, 99) < p_beat) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data = mem_words[int'(req_addr[9:2]) + beats];
      end
    end else if ($urandom_range(0, 99) < p_stray) mem_rsp_valid = 1'b1;
    hit = lv && line_addr[31:4] == pc_imem[31:4];
    e.stall = !hit;
    e.instr = hit ? mem_words[pc_imem[9:2]] : NOP;
    e.rv = req_out;
    e.ca = req_out || !rst_n;
    e.ra = req_out ? req_addr : 32'h0;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (!busy) begin
        if (invalidate) lv = 0;
        else if (!hit) begin
          busy = 1; req_out = 1; lv = 0; drop = 0;
          req_addr = {pc_imem[31:4], 4'b0};
        end
      end else begin
        if (invalidate) drop = 1;
        if (req_out) begin
          if (mem_req_ready) begin req_out = 0; beats = 0; end
        end else if (mem_rsp_valid) begin
          beats++;
          if (beats == W) begin busy = 0; lv = !drop; line_addr = req_addr; end
        end
      end
    end
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic until_beats(input int n);
    for (int i = 0; i < 60 && !(busy && !req_out && beats >= n); i++) step();
    checks++;
    if (busy && !req_out && beats >= n) passed++;
    else $display("FAIL fill_timeout at %0t: beats %0d expected %0d", $time, beats, n);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem_words[i] = $urandom;
    for (int i = 0; i < 4; i++) mem_words[i] = 32'hA0 + i;
    @(posedge clk);
    #1;
    pc_imem = 32'h0;
    run(2);
    rst_n = 1'b1;
    run(8);
    pc_imem = 32'hC;
    run(2);
    pc_imem = 32'h10;
    p_ready = 0;
    run(4);
    p_ready = 100;
    run(8);
    pc_imem = 32'h0;
    run(8);
    pc_imem = 32'h20;
    until_beats(1);
    pc_imem = 32'h40;
    run(12);
    pc_imem = 32'h30;
    until_beats(1);
    invalidate = 1'b1;
    step();
    invalidate = 1'b0;
    run(14);
    pc_imem = 32'h34;
    p_stray = 100;
    run(5);
    p_stray = 0;
    pc_imem = 32'h50;
    until_beats(2);
    rst_n = 1'b0;
    p_stray = 100;
    run(2);
    rst_n = 1'b1;
    p_stray = 0;
    run(10);
    p_ready = 60;
    p_beat = 70;
    p_stray = 20;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 20)
        pc_imem = ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      invalidate = $urandom_range(0, 99) < 3;
      step();
    end
    invalidate = 1'b0;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
